// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: synchronises the receiver's byte strobe, parses
// E0/F0 prefixes, tracks game-key held flags and queues events in a FWFT FIFO.
module ps2_scancode_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] PS2_BYTE,
  input  logic       PS2_NEWDATA,
  input  logic       EVT_POP,
  output logic       EVT_VALID,
  output logic [7:0] EVT_CODE,
  output logic       EVT_EXT,
  output logic       EVT_BREAK,
  output logic       EVT_OVERFLOW,
  output logic       KEY_SPACE_HELD,
  output logic       KEY_W_HELD,
  output logic       KEY_ESC_HELD,
  output logic [1:0] dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3} state_t;

  state_t          state, state_next;
  logic [TW-1:0]   timer, timer_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic            synced_prev;
  logic            fall;
  logic [7:0]      byte_q;
  logic            byte_stb;
  logic            is_status, is_e0, is_f0, ext_now, brk_now;
  logic            push, push_ext, push_brk;
  logic            do_push, do_pop, full;
  logic [9:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  // Falling edge of the synchronised frame flag marks a freshly presented byte.
  assign fall = synced_prev & ~sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q      <= '0;
      synced_prev <= 1'b0;
      byte_q      <= 8'h00;
      byte_stb    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], PS2_NEWDATA};
      synced_prev <= sync_q[SYNC_STAGES-1];
      byte_stb    <= fall;
      if (fall) byte_q <= PS2_BYTE;
    end
  end

  assign is_status = (byte_q == 8'h00) || (byte_q == 8'hAA) || (byte_q == 8'hEE) ||
                     (byte_q == 8'hFA) || (byte_q == 8'hFE) || (byte_q == 8'hFF);
  assign is_e0   = (byte_q == 8'hE0);
  assign is_f0   = (byte_q == 8'hF0);
  assign ext_now = (state == EXT) || (state == EXT_BRK);
  assign brk_now = (state == BRK) || (state == EXT_BRK);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // A prefix only adds its own flag, so the prefix states merge orthogonally.
  always_comb begin
    state_next = state;
    timer_next = timer;
    push       = 1'b0;
    push_ext   = 1'b0;
    push_brk   = 1'b0;
    if (byte_stb) begin
      timer_next = '0;
      if (is_status) begin
        state_next = IDLE;
      end else if (is_e0) begin
        state_next = brk_now ? EXT_BRK : EXT;
      end else if (is_f0) begin
        state_next = ext_now ? EXT_BRK : BRK;
      end else begin
        push       = 1'b1;
        push_ext   = ext_now;
        push_brk   = brk_now;
        state_next = IDLE;
      end
    end else if (state != IDLE) begin
      if (timer == TO_MAX) begin
        state_next = IDLE;
        timer_next = '0;
      end else begin
        timer_next = timer + 1'b1;
      end
    end else begin
      timer_next = '0;
    end
  end

  assign dbg_state = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      KEY_SPACE_HELD <= 1'b0;
      KEY_W_HELD     <= 1'b0;
      KEY_ESC_HELD   <= 1'b0;
    end else if (push && !push_ext) begin
      if (byte_q == 8'h29) KEY_SPACE_HELD <= !push_brk;
      if (byte_q == 8'h1D) KEY_W_HELD     <= !push_brk;
      if (byte_q == 8'h76) KEY_ESC_HELD   <= !push_brk;
    end
  end

  // FIFO handshake: EVT_POP consumes the head only when EVT_VALID is high; a
  // push into a full FIFO succeeds only if a pop frees a slot in the same cycle.
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = EVT_POP && (count != '0);
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      EVT_OVERFLOW <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {push_ext, push_brk, byte_q};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (push && !do_push) EVT_OVERFLOW <= 1'b1;
    end
  end

  assign EVT_VALID = (count != '0);
  assign EVT_EXT   = mem[rd_ptr][9];
  assign EVT_BREAK = mem[rd_ptr][8];
  assign EVT_CODE  = mem[rd_ptr][7:0];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: table of byte sequences with expected events
// and held flags, plus hand-written overflow, timeout, reset and pop sequences.
module tb_ps2_scancode_decoder;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] PS2_BYTE = 8'h00;
  logic       PS2_NEWDATA = 1'b0;
  logic       EVT_POP = 1'b0;
  logic       EVT_VALID, EVT_EXT, EVT_BREAK, EVT_OVERFLOW;
  logic [7:0] EVT_CODE;
  logic       KEY_SPACE_HELD, KEY_W_HELD, KEY_ESC_HELD;
  logic [1:0] dbg_state;

  int checks = 0;
  int passed = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    int         n;
    logic [7:0] b0, b1, b2;
    bit         has_evt;
    logic [9:0] evt;   // {ext, brk, code}
    logic [2:0] held;  // {esc, w, space}
  } vec_t;

  vec_t vecs[13];

  ps2_scancode_decoder #(.SYNC_STAGES(2), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(100)) dut (
    .CLK(CLK), .RESET(RESET), .PS2_BYTE(PS2_BYTE), .PS2_NEWDATA(PS2_NEWDATA),
    .EVT_POP(EVT_POP), .EVT_VALID(EVT_VALID), .EVT_CODE(EVT_CODE), .EVT_EXT(EVT_EXT),
    .EVT_BREAK(EVT_BREAK), .EVT_OVERFLOW(EVT_OVERFLOW), .KEY_SPACE_HELD(KEY_SPACE_HELD),
    .KEY_W_HELD(KEY_W_HELD), .KEY_ESC_HELD(KEY_ESC_HELD), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Present a byte and drop the frame flag; returns right at the falling edge.
  task automatic fall_byte(input logic [7:0] b);
    PS2_NEWDATA = 1'b1;
    tick(2);
    PS2_BYTE = b;
    PS2_NEWDATA = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    fall_byte(b);
    tick(6);
  endtask

  task automatic expect_event(input string name);
    int waited = 0;
    logic [9:0] exp;
    while (!EVT_VALID && waited < 20) begin
      tick(1);
      waited++;
    end
    if (!EVT_VALID) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
    end else if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, {EVT_EXT, EVT_BREAK, EVT_CODE}, 32'h3ff);
    end else begin
      exp = exp_q.pop_front();
      check(name, {EVT_EXT, EVT_BREAK, EVT_CODE}, exp);
      EVT_POP = 1'b1;
      tick(1);
      EVT_POP = 1'b0;
    end
  endtask

  function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input bit he, input logic [9:0] ev,
                              input logic [2:0] held);
    vec_t v;
    v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.has_evt = he; v.evt = ev; v.held = held;
    return v;
  endfunction

  initial begin
    int lat;
    int vcyc;
    vecs[0]  = mk(1, 8'h29, 8'h00, 8'h00, 1, {2'b00, 8'h29}, 3'b001);
    vecs[1]  = mk(2, 8'hF0, 8'h29, 8'h00, 1, {2'b01, 8'h29}, 3'b000);
    vecs[2]  = mk(2, 8'hE0, 8'h1D, 8'h00, 1, {2'b10, 8'h1D}, 3'b000);
    vecs[3]  = mk(3, 8'hE0, 8'hF0, 8'h75, 1, {2'b11, 8'h75}, 3'b000);
    vecs[4]  = mk(1, 8'hAA, 8'h00, 8'h00, 0, 10'h000,         3'b000);
    vecs[5]  = mk(1, 8'h1D, 8'h00, 8'h00, 1, {2'b00, 8'h1D}, 3'b010);
    vecs[6]  = mk(1, 8'h1D, 8'h00, 8'h00, 1, {2'b00, 8'h1D}, 3'b010);
    vecs[7]  = mk(3, 8'hF0, 8'hE0, 8'h1D, 1, {2'b11, 8'h1D}, 3'b010);
    vecs[8]  = mk(2, 8'hF0, 8'h1D, 8'h00, 1, {2'b01, 8'h1D}, 3'b000);
    vecs[9]  = mk(1, 8'h76, 8'h00, 8'h00, 1, {2'b00, 8'h76}, 3'b100);
    vecs[10] = mk(3, 8'hE0, 8'hFA, 8'h29, 1, {2'b00, 8'h29}, 3'b101);
    vecs[11] = mk(2, 8'hF0, 8'h29, 8'h00, 1, {2'b01, 8'h29}, 3'b100);
    vecs[12] = mk(2, 8'hF0, 8'h76, 8'h00, 1, {2'b01, 8'h76}, 3'b000);

    // Reset state
    tick(3);
    check("rst_valid", EVT_VALID, 0);
    check("rst_overflow", EVT_OVERFLOW, 0);
    check("rst_held", {KEY_ESC_HELD, KEY_W_HELD, KEY_SPACE_HELD}, 0);
    check("rst_state", dbg_state, 0);
    RESET = 1'b0;
    tick(2);

    // Latency of the first byte
    fall_byte(8'h29);
    lat = 99;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (EVT_VALID && lat == 99) lat = k;
    end
    check("latency_le4", lat <= 4, 1);
    exp_q.push_back({2'b00, 8'h29});
    expect_event("lat_evt");
    check("lat_space", KEY_SPACE_HELD, 1);
    send_byte(8'hF0);
    send_byte(8'h29);
    exp_q.push_back({2'b01, 8'h29});
    expect_event("lat_brk_evt");
    check("lat_space_clr", KEY_SPACE_HELD, 0);

    // Table-driven sequences
    for (int i = 0; i < 13; i++) begin
      send_byte(vecs[i].b0);
      if (vecs[i].n > 1) send_byte(vecs[i].b1);
      if (vecs[i].n > 2) send_byte(vecs[i].b2);
      if (vecs[i].has_evt) begin
        exp_q.push_back(vecs[i].evt);
        expect_event($sformatf("vec%0d_evt", i));
      end else begin
        check($sformatf("vec%0d_noevt", i), EVT_VALID, 0);
      end
      check($sformatf("vec%0d_held", i), {KEY_ESC_HELD, KEY_W_HELD, KEY_SPACE_HELD}, vecs[i].held);
      check($sformatf("vec%0d_state", i), dbg_state, 0);
    end

    // Overflow, then simultaneous pop and push while full
    send_byte(8'h16); exp_q.push_back({2'b00, 8'h16});
    send_byte(8'h1E); exp_q.push_back({2'b00, 8'h1E});
    send_byte(8'h26); exp_q.push_back({2'b00, 8'h26});
    send_byte(8'h25); exp_q.push_back({2'b00, 8'h25});
    check("full_no_ovf", EVT_OVERFLOW, 0);
    send_byte(8'h2E);
    check("ovf_set", EVT_OVERFLOW, 1);
    // Byte is pushed on the fourth edge after the fall; pop during that edge.
    fall_byte(8'h36);
    tick(3);
    check("full_head", {EVT_EXT, EVT_BREAK, EVT_CODE}, exp_q.pop_front());
    EVT_POP = 1'b1;
    tick(1);
    EVT_POP = 1'b0;
    exp_q.push_back({2'b00, 8'h36});
    tick(2);
    check("pushpop_head", EVT_CODE, 8'h1E);
    for (int i = 0; i < 4; i++) expect_event($sformatf("drain%0d", i));
    check("drain_empty", EVT_VALID, 0);
    check("ovf_sticky", EVT_OVERFLOW, 1);

    // Prefix timeout
    send_byte(8'hE0);
    check("to_in_ext", dbg_state, 1);
    tick(120);
    check("to_idle", dbg_state, 0);
    send_byte(8'h1D);
    exp_q.push_back({2'b00, 8'h1D});
    expect_event("to_evt");
    check("to_w_held", KEY_W_HELD, 1);

    // Status code, partial sequence, reset
    send_byte(8'hAA);
    check("aa_noevt", EVT_VALID, 0);
    send_byte(8'hF0);
    check("f0_brk", dbg_state, 2);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    check("rst2_state", dbg_state, 0);
    check("rst2_ovf", EVT_OVERFLOW, 0);
    check("rst2_w", KEY_W_HELD, 0);
    send_byte(8'h76);
    exp_q.push_back({2'b00, 8'h76});
    expect_event("rst2_evt");
    check("rst2_esc", KEY_ESC_HELD, 1);
    check("rst2_ovf_after", EVT_OVERFLOW, 0);

    // Pop held while empty, then one byte
    EVT_POP = 1'b1;
    tick(5);
    check("pop_empty", EVT_VALID, 0);
    fall_byte(8'h29);
    vcyc = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (EVT_VALID) begin
        vcyc++;
        check("pop_held_code", {EVT_EXT, EVT_BREAK, EVT_CODE}, {2'b00, 8'h29});
      end
    end
    check("pop_held_one_cycle", vcyc, 1);
    check("pop_held_empty", EVT_VALID, 0);
    EVT_POP = 1'b0;
    check("pop_held_space", KEY_SPACE_HELD, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Downstream consumer of the PS/2 byte receiver (the PS2Controller stage). It sits in the system clock domain.
- Brings the receiver's byte/strobe pair across from the PS/2 clock domain and parses Set-2 scan-code sequences: E0 extended prefix, F0 break prefix, and status codes.
- Keeps key-held flags for the game keys and queues decoded press/release events in a small first-word-fall-through FIFO for the control logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages synchronising PS2_NEWDATA (minimum 2).
FIFO_DEPTH, 4, event FIFO entries (power of 2, at least 2).
TIMEOUT_CYCLES, 1000000, CLK cycles a prefix state may wait for its next byte before being abandoned (20 ms at 50 MHz).

Ports:
CLK  input  1  system clock, rising edge.
RESET  input  1  asynchronous, active-high reset.
PS2_BYTE  input  8  last received byte from the PS/2 receiver. Stable whenever PS2_NEWDATA falls.
PS2_NEWDATA  input  1  receiver frame flag, asynchronous to CLK. A falling edge means a new byte has been presented.
EVT_POP  input  1  consumer removes the head event this cycle.
EVT_VALID  output  1  FIFO not empty.
EVT_CODE  output  8  head event scan code.
EVT_EXT  output  1  head event had the E0 prefix.
EVT_BREAK  output  1  head event is a release (F0 seen).
EVT_OVERFLOW  output  1  sticky: an event was dropped because the FIFO was full.
KEY_SPACE_HELD  output  1  space (0x29, non-extended) is currently down.
KEY_W_HELD  output  1  W (0x1D, non-extended) is currently down.
KEY_ESC_HELD  output  1  ESC (0x76, non-extended) is currently down.

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs 0. FSM goes to IDLE. FIFO empty. Timeout counter 0. Sync chain and edge register 0.
  - Any partial sequence in progress at reset is discarded.
- Input capture:
  - PS2_NEWDATA passes through SYNC_STAGES flops.
  - A byte is taken in the cycle where the synced value is 0 and its registered copy is 1 (falling edge). PS2_BYTE is registered in that same cycle.
  - Rising edges are ignored.
- Byte classification:
  - 0x00, 0xAA, 0xEE, 0xFA, 0xFE and 0xFF are status codes. In any state: no event, FSM returns to IDLE.
- FSM, states IDLE, EXT, BRK, EXT_BRK:
  - IDLE: E0 -> EXT. F0 -> BRK. Other -> push make {ext=0}, stay in IDLE.
  - EXT: E0 -> EXT. F0 -> EXT_BRK. Other -> push make {ext=1}, go to IDLE.
  - BRK: F0 -> BRK. E0 -> EXT_BRK. Other -> push break {ext=0}, go to IDLE.
  - EXT_BRK: E0/F0 -> EXT_BRK. Other -> push break {ext=1}, go to IDLE.
- Timeout:
  - In EXT, BRK or EXT_BRK the counter increments each cycle and is cleared on every accepted byte.
  - When the count reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE on the next edge. No event is pushed.
  - The counter is held at 0 in IDLE.
- Held flags:
  - Updated on the same edge as the push.
  - A non-extended make of the key's code sets the flag; a non-extended break clears it.
  - Extended codes never affect the flags.
  - Typematic repeat makes push events as normal; the flag stays 1.
- Latency: the first CLK edge sampling PS2_NEWDATA low is edge 0. The event is visible on EVT_VALID / EVT_* by edge SYNC_STAGES+2.
- FIFO:
  - Entry is {ext, brk, code}, 10 bits. First-word fall-through: EVT_* always shows the head, and are don't-care when EVT_VALID=0.
  - EVT_POP with EVT_VALID=1 advances the head. EVT_POP when empty is ignored.
  - Push when full without a pop: the new event is dropped and EVT_OVERFLOW is set until reset.
  - Push and pop in the same cycle when full: both take effect, count is unchanged, no overflow.
  - Push and pop in the same cycle when count is 1: the head is replaced and EVT_VALID stays 1.
  - Pointers wrap modulo FIFO_DEPTH. An explicit count or extra pointer bit separates full from empty.

Test Plan:
1. Bytes 0x29 then 0xF0,0x29, with EVT_POP pulsed per event -> two events {0,0,0x29} then {0,1,0x29}. KEY_SPACE_HELD rises, then falls. EVT_VALID rises no later than edge 4 after NEWDATA falls.
2. Bytes 0xE0,0x1D then 0xE0,0xF0,0x75 -> events {1,0,0x1D} and {1,1,0x75}. KEY_W_HELD stays 0. FSM ends in IDLE.
3. Five makes 0x16,0x1E,0x26,0x25,0x2E with no pop (FIFO_DEPTH=4) -> 4 entries 0x16..0x25 in order. 0x2E dropped, EVT_OVERFLOW=1. Then pop together with a push of 0x36 -> head 0x1E, 0x36 held at tail, count stays 4.
4. TIMEOUT_CYCLES=100: byte 0xE0, wait 120 cycles, then byte 0x1D -> event {0,0,0x1D}, KEY_W_HELD=1.
5. Bytes 0xAA, then 0xF0, RESET pulse, then 0x76 -> no event for 0xAA. After reset, event {0,0,0x76}, KEY_ESC_HELD=1, EVT_OVERFLOW=0.
6. EVT_POP held high while empty, then byte 0x29 -> no underflow. Event appears, is consumed on the next edge, and EVT_VALID returns to 0.
